// File: rtl/clk_gate_ctrl_if.sv
// Activity inputs and gate-control outputs of the clock gating controller.
// The controller takes the slave view; the activity source takes the master view.
interface clk_gate_ctrl_if;
    logic busy_i;
    logic wake_req_i;
    logic force_on_i;
    logic gate_en_o;
    logic clk_active_o;
    logic wake_ack_o;
    logic sleep_o;

    modport master (
        output busy_i,
        output wake_req_i,
        output force_on_i,
        input  gate_en_o,
        input  clk_active_o,
        input  wake_ack_o,
        input  sleep_o
    );

    modport slave (
        input  busy_i,
        input  wake_req_i,
        input  force_on_i,
        output gate_en_o,
        output clk_active_o,
        output wake_ack_o,
        output sleep_o
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Idle-detection controller for a gated-clock cell enable.
// It runs on the free clock and models the cell's enable-synchronizer latency.
module clk_gate_ctrl #(
    parameter int IDLE_CYCLES  = 16,
    parameter int SYNC_LATENCY = 2
) (
    input logic            clk_i,
    input logic            arst_ni,
    clk_gate_ctrl_if.slave bus
);
    localparam int IW_RAW = $clog2(IDLE_CYCLES + 1);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;
    localparam int LW     = $clog2(SYNC_LATENCY + 1);

    localparam logic [IW-1:0] IDLE_LAST =
        IW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
    localparam logic [LW-1:0] LAT_LAST = LW'(SYNC_LATENCY - 1);

    typedef enum logic [2:0] {
        RUN,
        IDLE_WAIT,
        SLEEP_PEND,
        SLEEP,
        WAKE_PEND
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          gate_q, act_q, ack_q, sleep_q;
    logic          quiet;

    assign quiet = !bus.busy_i && !bus.wake_req_i && !bus.force_on_i;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        lat_d   = lat_q;
        unique case (state_q)
            RUN: begin
                if (quiet && IDLE_CYCLES != 0) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = SLEEP_PEND;
                        lat_d   = '0;
                        idle_d  = '0;
                    end else begin
                        state_d = IDLE_WAIT;
                        idle_d  = IW'(1);
                    end
                end
            end
            IDLE_WAIT: begin
                if (!quiet) begin
                    state_d = RUN;
                    idle_d  = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = SLEEP_PEND;
                    lat_d   = '0;
                    idle_d  = '0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + IW'(1);
                end
            end
            // Never cut short: a partial window could emit a runt gated pulse.
            SLEEP_PEND: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = quiet ? SLEEP : WAKE_PEND;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            SLEEP: begin
                if (!quiet) begin
                    state_d = WAKE_PEND;
                    lat_d   = '0;
                end
            end
            WAKE_PEND: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RUN;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: begin
                state_d = WAKE_PEND;
                lat_d   = '0;
                idle_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= WAKE_PEND;
            idle_q  <= '0;
            lat_q   <= '0;
            gate_q  <= 1'b1;
            act_q   <= 1'b0;
            ack_q   <= 1'b0;
            sleep_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idle_q  <= idle_d;
            lat_q   <= lat_d;
            gate_q  <= (state_d == RUN) || (state_d == IDLE_WAIT) ||
                       (state_d == WAKE_PEND);
            act_q   <= (state_d == RUN) || (state_d == IDLE_WAIT);
            ack_q   <= (state_q == WAKE_PEND) && (state_d == RUN);
            sleep_q <= (state_d == SLEEP);
        end
    end

    assign bus.gate_en_o    = gate_q;
    assign bus.clk_active_o = act_q;
    assign bus.wake_ack_o   = ack_q;
    assign bus.sleep_o      = sleep_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench: three controller configurations driven by shared random
// activity, checked against a timer-based reference model.
module tb_clk_gate_ctrl;
    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy  = 1'b1;
    logic wake  = 1'b0;
    logic force_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clk_gate_ctrl_if ia ();
    clk_gate_ctrl_if ib ();
    clk_gate_ctrl_if ic ();

    assign ia.busy_i = busy;
    assign ia.wake_req_i = wake;
    assign ia.force_on_i = force_on;
    assign ib.busy_i = busy;
    assign ib.wake_req_i = wake;
    assign ib.force_on_i = force_on;
    assign ic.busy_i = busy;
    assign ic.wake_req_i = wake;
    assign ic.force_on_i = force_on;

    clk_gate_ctrl #(.IDLE_CYCLES(4), .SYNC_LATENCY(2)) u_a (
        .clk_i(clk), .arst_ni(rst_n), .bus(ia)
    );
    clk_gate_ctrl #(.IDLE_CYCLES(0), .SYNC_LATENCY(2)) u_b (
        .clk_i(clk), .arst_ni(rst_n), .bus(ib)
    );
    clk_gate_ctrl #(.IDLE_CYCLES(1), .SYNC_LATENCY(3)) u_c (
        .clk_i(clk), .arst_ni(rst_n), .bus(ic)
    );

    // {gate_en, clk_active, wake_ack, sleep}
    logic [3:0] act [N];
    assign act[0] = {ia.gate_en_o, ia.clk_active_o, ia.wake_ack_o, ia.sleep_o};
    assign act[1] = {ib.gate_en_o, ib.clk_active_o, ib.wake_ack_o, ib.sleep_o};
    assign act[2] = {ic.gate_en_o, ic.clk_active_o, ic.wake_ack_o, ic.sleep_o};

    int idle_p [N] = '{4, 0, 1};
    int sync_p [N] = '{2, 2, 3};

    // Model: current enable level, cycles left before the clock reflects it,
    // length of the current quiet run, and a wake-complete flag.
    int m_gate [N];
    int m_pend [N];
    int m_qrun [N];
    int m_ack  [N];
    logic [3:0] exp_q [N][$];

    function automatic logic [3:0] expect_of(int i);
        logic g, a, k, s;
        g = (m_gate[i] != 0);
        a = (m_gate[i] != 0) && (m_pend[i] == 0);
        k = (m_ack[i] != 0);
        s = (m_gate[i] == 0) && (m_pend[i] == 0);
        return {g, a, k, s};
    endfunction

    task automatic model_reset(int i);
        m_gate[i] = 1;
        m_pend[i] = sync_p[i];
        m_qrun[i] = 0;
        m_ack[i]  = 0;
    endtask

    task automatic model_step(int i, bit quiet);
        m_ack[i] = 0;
        if (m_pend[i] > 0) begin
            m_pend[i]--;
            if (m_pend[i] == 0) begin
                if (m_gate[i] != 0) begin
                    m_ack[i] = 1;
                end else if (!quiet) begin
                    m_gate[i] = 1;
                    m_pend[i] = sync_p[i];
                end
            end
        end else if (m_gate[i] != 0) begin
            if (quiet) begin
                m_qrun[i]++;
                if (idle_p[i] > 0 && m_qrun[i] >= idle_p[i]) begin
                    m_gate[i] = 0;
                    m_pend[i] = sync_p[i];
                    m_qrun[i] = 0;
                end
            end else begin
                m_qrun[i] = 0;
            end
        end else if (!quiet) begin
            m_gate[i] = 1;
            m_pend[i] = sync_p[i];
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i, !busy && !wake && !force_on);
            exp_q[i].push_back(expect_of(i));
        end
    end

    task automatic check(string name, logic [3:0] got, logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b want %b", name, $time, got, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL scoreboard%0d at %0t: got empty want entry", i, $time);
            end else begin
                check($sformatf("outputs%0d", i), act[i], exp_q[i].pop_front());
            end
        end
    end

    task automatic cyc(int n, bit b, bit w, bit f);
        repeat (n) begin
            @(negedge clk);
            busy = b;
            wake = w;
            force_on = f;
        end
    endtask

    task automatic async_reset(string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_rst%0d", tag, i), act[i], 4'b1000);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cyc(6, 1, 0, 0);
        cyc(12, 0, 0, 0);
        cyc(3, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(10, 0, 0, 0);
        cyc(6, 1, 0, 0);
        cyc(4, 0, 0, 0);
        cyc(4, 0, 1, 0);
        cyc(6, 1, 0, 0);
        cyc(12, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(10, 0, 0, 0);
        cyc(12, 0, 0, 0);
        cyc(1, 1, 0, 0);
        async_reset("wake_pend");
        cyc(8, 1, 0, 0);
        cyc(12, 0, 0, 0);
        async_reset("sleep");
        cyc(8, 1, 0, 0);
        for (int blk = 0; blk < 30; blk++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < 12; k++) begin
                bit b, w, f;
                b = 1'b0;
                w = 1'b0;
                f = 1'b0;
                if (mode == 0) begin
                    b = ($urandom_range(0, 15) == 0);
                end else if (mode == 1) begin
                    b = $urandom_range(0, 1) != 0;
                    w = ($urandom_range(0, 3) == 0);
                end else begin
                    w = ($urandom_range(0, 5) == 0);
                    f = ($urandom_range(0, 7) == 0);
                end
                cyc(1, b, w, f);
            end
        end
        cyc(20, 0, 0, 0);
        @(posedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
